ace_domain_tagger: RTL and testbench



---
 rtl/ace_domain_tagger_pkg.sv | 56 +++++
 rtl/ace_domain_tagger_region_match.sv | 35 +++
 rtl/ace_domain_tagger.sv | 102 ++++++++++
 tb/tb_ace_domain_tagger.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_domain_tagger_pkg.sv
// Shared types, ACE encodings and reset-table helpers for the domain tagger.
package ace_domain_tagger_pkg;

  localparam int MaxRules = 16;
  localparam logic [63:0] DRAMBase = 64'h8000_0000;

  // attr bit positions: {shareable, cacheable}
  localparam int AttrSh = 1;
  localparam int AttrC  = 0;

  localparam logic [1:0] DomainNonShare = 2'b00;
  localparam logic [1:0] DomainInner    = 2'b01;

  localparam logic [3:0] SnoopReadNoSnoop  = 4'b0000;
  localparam logic [3:0] SnoopReadShared   = 4'b0001;
  localparam logic [3:0] SnoopWriteNoSnoop = 4'b0000;
  localparam logic [3:0] SnoopWriteUnique  = 4'b0000;

  // Rules are held at full 64-bit width; narrower addresses are zero-extended.
  typedef struct packed {
    logic [63:0] base;
    logic [63:0] len;
    logic [1:0]  attr;
  } rule_t;

  function automatic logic [MaxRules-1:0][63:0] default_base();
    logic [MaxRules-1:0][63:0] b;
    b    = '0;
    b[0] = DRAMBase + 64'h4_0000;
    return b;
  endfunction

  function automatic logic [MaxRules-1:0][63:0] default_len();
    logic [MaxRules-1:0][63:0] l;
    l    = '0;
    l[0] = 64'h4_0000;
    return l;
  endfunction

  function automatic logic [MaxRules-1:0][1:0] default_attr();
    logic [MaxRules-1:0][1:0] a;
    a    = '0;
    a[0] = 2'b11;
    return a;
  endfunction

  function automatic logic [1:0] tag_domain(input logic [1:0] attr);
    return attr[AttrSh] ? DomainInner : DomainNonShare;
  endfunction

  function automatic logic [3:0] tag_snoop(input logic [1:0] attr, input logic write);
    if (write) return attr[AttrSh] ? SnoopWriteUnique : SnoopWriteNoSnoop;
    return attr[AttrSh] ? SnoopReadShared : SnoopReadNoSnoop;
  endfunction

endpackage

// File: rtl/ace_domain_tagger_region_match.sv
// Combinational region lookup: per-rule range compare plus lowest-index priority pick.
module ace_region_match
  import ace_domain_tagger_pkg::*;
#(
  parameter int NrRules = 4
) (
  input  logic [63:0]              addr_i,
  input  rule_t [NrRules-1:0]      rules_i,
  output logic                     hit_o,
  output logic [1:0]               attr_o
);

  logic [NrRules-1:0] hits;

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    // 65-bit limit so a region running past the top of memory covers up to it
    logic [64:0] lim;
    assign lim     = {1'b0, rules_i[g].base} + {1'b0, rules_i[g].len};
    assign hits[g] = (rules_i[g].len != '0) && (addr_i >= rules_i[g].base) &&
                     ({1'b0, addr_i} < lim);
  end

  // Walk high to low so the lowest-index hit is the one left standing
  always_comb begin
    hit_o  = 1'b0;
    attr_o = 2'b00;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit_o  = 1'b1;
        attr_o = rules_i[i].attr;
      end
    end
  end

endmodule

// File: rtl/ace_domain_tagger.sv
// ACE attribute tagger: region table, one-deep output slice and hit counters.
module ace_domain_tagger
  import ace_domain_tagger_pkg::*;
#(
  parameter int NrRules      = 4,
  parameter int AddrWidth    = 64,
  parameter int PayloadWidth = 128,
  parameter int CntWidth     = 32,
  parameter logic [MaxRules-1:0][63:0] DefaultBase = default_base(),
  parameter logic [MaxRules-1:0][63:0] DefaultLen  = default_len(),
  parameter logic [MaxRules-1:0][1:0]  DefaultAttr = default_attr(),
  localparam int IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [PayloadWidth-1:0] req_payload_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_write_o,
  output logic [AddrWidth-1:0]    out_addr_o,
  output logic [PayloadWidth-1:0] out_payload_o,
  output logic [1:0]              out_domain_o,
  output logic [3:0]              out_snoop_o,
  output logic                    out_cacheable_o,
  input  logic                    cfg_we_i,
  input  logic [IdxW-1:0]         cfg_idx_i,
  input  logic [AddrWidth-1:0]    cfg_base_i,
  input  logic [AddrWidth-1:0]    cfg_len_i,
  input  logic [1:0]              cfg_attr_i,
  output logic [CntWidth-1:0]     cnt_shared_o,
  output logic [CntWidth-1:0]     cnt_total_o
);

  rule_t [NrRules-1:0] table_q;
  logic                m_hit;
  logic [1:0]          m_attr, attr;
  logic                accept;

  ace_region_match #(.NrRules(NrRules)) i_match (
    .addr_i  (64'(req_addr_i)),
    .rules_i (table_q),
    .hit_o   (m_hit),
    .attr_o  (m_attr)
  );

  assign attr        = m_hit ? m_attr : 2'b00;
  assign req_ready_o = !out_valid_o || out_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // Region table: lookup sees the pre-edge contents, so a same-cycle write
  // only affects the following requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        table_q[i].base <= DefaultBase[i];
        table_q[i].len  <= DefaultLen[i];
        table_q[i].attr <= DefaultAttr[i];
      end
    end else if (cfg_we_i && (int'(cfg_idx_i) < NrRules)) begin
      table_q[cfg_idx_i] <= '{base: 64'(cfg_base_i), len: 64'(cfg_len_i), attr: cfg_attr_i};
    end
  end

  // Output register slice: load on accept, clear valid on a drain-only handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o     <= 1'b0;
      out_write_o     <= 1'b0;
      out_addr_o      <= '0;
      out_payload_o   <= '0;
      out_domain_o    <= 2'b00;
      out_snoop_o     <= 4'b0000;
      out_cacheable_o <= 1'b0;
    end else if (accept) begin
      out_valid_o     <= 1'b1;
      out_write_o     <= req_write_i;
      out_addr_o      <= req_addr_i;
      out_payload_o   <= req_payload_i;
      out_domain_o    <= tag_domain(attr);
      out_snoop_o     <= tag_snoop(attr, req_write_i);
      out_cacheable_o <= attr[AttrC];
    end else if (out_ready_i) begin
      out_valid_o     <= 1'b0;
    end
  end

  // Saturating accept statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_total_o  <= '0;
      cnt_shared_o <= '0;
    end else if (accept) begin
      if (cnt_total_o != '1) cnt_total_o <= cnt_total_o + 1'b1;
      if (attr[AttrSh] && (cnt_shared_o != '1)) cnt_shared_o <= cnt_shared_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_ace_domain_tagger.sv
// Directed bench for ace_domain_tagger with a reference table model and output scoreboard.
module tb_ace_domain_tagger;

  localparam int NR = 3;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [63:0]  req_addr = '0;
  logic [127:0] req_payload = '0;
  logic         out_valid, out_ready = 1'b1, out_write, out_cacheable;
  logic [63:0]  out_addr;
  logic [127:0] out_payload;
  logic [1:0]   out_domain;
  logic [3:0]   out_snoop;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_idx = '0;
  logic [63:0]  cfg_base = '0, cfg_len = '0;
  logic [1:0]   cfg_attr = '0;
  logic [CW-1:0] cnt_shared, cnt_total;

  always #5 clk = ~clk;

  ace_domain_tagger #(.NrRules(NR), .AddrWidth(64), .PayloadWidth(128), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_payload_i(req_payload),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_write_o(out_write),
    .out_addr_o(out_addr), .out_payload_o(out_payload), .out_domain_o(out_domain),
    .out_snoop_o(out_snoop), .out_cacheable_o(out_cacheable),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_base_i(cfg_base),
    .cfg_len_i(cfg_len), .cfg_attr_i(cfg_attr),
    .cnt_shared_o(cnt_shared), .cnt_total_o(cnt_total)
  );

  typedef struct {
    logic         w;
    logic [63:0]  addr;
    logic [127:0] pay;
    logic [1:0]   dom;
    logic [3:0]   snp;
    logic         c;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  logic [63:0]  m_base[NR];
  logic [63:0]  m_len[NR];
  logic [1:0]   m_attr[NR];
  int           m_total, m_shared;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic w, input logic [63:0] a, input logic [127:0] p);
    exp_t e;
    logic [1:0] at;
    at = 2'b00;
    for (int i = 0; i < NR; i++) begin
      if (m_len[i] != 0 && a >= m_base[i] && ({1'b0, a} < ({1'b0, m_base[i]} + {1'b0, m_len[i]}))) begin
        at = m_attr[i];
        break;
      end
    end
    e.w = w; e.addr = a; e.pay = p;
    e.dom = at[1] ? 2'b01 : 2'b00;
    e.snp = (at[1] && !w) ? 4'b0001 : 4'b0000;
    e.c = at[0];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = '0; m_len[i] = '0; m_attr[i] = '0;
    end
    m_base[0] = 64'h8004_0000; m_len[0] = 64'h4_0000; m_attr[0] = 2'b11;
    m_total = 0; m_shared = 0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Present a request, push its expectation when the DUT will take it
  task automatic send(input logic w, input logic [63:0] a);
    exp_t e;
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a;
    req_payload = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin chk("accept_timeout", req_ready, 1'b1); break; end
    end
    e = model(w, a, req_payload);
    q.push_back(e);
    if (m_total < 15) m_total++;
    if (e.dom == 2'b01 && m_shared < 15) m_shared++;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [63:0] b, input logic [63:0] l, input logic [1:0] at);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = b; cfg_len = l; cfg_attr = at;
    @(posedge clk);
    if (int'(idx) < NR) begin m_base[idx] = b; m_len[idx] = l; m_attr[idx] = at; end
    #1 cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1 chk("drain_left", q.size(), 0);
  endtask

  // Scoreboard: compare every completed output handshake with the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk("out_write", out_write, e.w);
        chk("out_addr", out_addr, e.addr);
        chk("out_payload", out_payload, e.pay);
        chk("out_domain", out_domain, e.dom);
        chk("out_snoop", out_snoop, e.snp);
        chk("out_cacheable", out_cacheable, e.c);
      end
    end
  end

  initial begin
    logic [63:0] a_addr;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_out_tags", {out_write, out_domain, out_snoop, out_cacheable}, 0);
    chk("rst_cnt_total", cnt_total, 0);
    chk("rst_cnt_shared", cnt_shared, 0);

    // default table
    send(1'b0, 64'h8004_0010);
    send(1'b0, 64'h8000_0000);
    send(1'b1, 64'h8007_FFFF);
    send(1'b0, 64'h8008_0000);
    drain();
    chk("dflt_cnt_total", cnt_total, m_total);
    chk("dflt_cnt_shared", cnt_shared, m_shared);

    // priority between overlapping rules
    cfg(2'd0, 64'h8000_0000, 64'h1000, 2'b00);
    cfg(2'd1, 64'h8000_0000, 64'h1_0000, 2'b11);
    send(1'b0, 64'h8000_0800);
    send(1'b0, 64'h8000_1000);
    drain();

    // backpressure: first request parks in the slice, stall 4 cycles
    do_reset();
    out_ready = 1'b0;
    a_addr = 64'h8004_0100;
    send(1'b0, a_addr);
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_addr_hold", out_addr, a_addr);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b1, 64'h8000_0200);
    send(1'b0, 64'h8005_0000);
    drain();
    chk("bp_cnt_total", cnt_total, 3);

    // config write racing an accept: request sees the old rule
    do_reset();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_base = m_base[0]; cfg_len = '0; cfg_attr = m_attr[0];
    send(1'b0, 64'h8004_0000);
    m_len[0] = '0;
    cfg_we = 1'b0;
    send(1'b0, 64'h8004_0000);
    drain();

    // top-of-address-space region and out-of-range index
    cfg(2'd2, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 2'b11);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
    send(1'b0, 64'hFFFF_FFFF_FFFF_EFFF);
    cfg(2'd3, 64'h9000_0000, 64'h1000, 2'b11);
    send(1'b0, 64'h9000_0000);
    send(1'b1, 64'hFFFF_FFFF_FFFF_F000);
    drain();

    // counter saturation
    do_reset();
    repeat (20) send(1'b0, 64'h8004_0000);
    drain();
    chk("sat_cnt_total", cnt_total, m_total);
    chk("sat_cnt_shared", cnt_shared, m_shared);

    // reset while a request is stalled in the slice
    out_ready = 1'b0;
    send(1'b0, 64'h8004_0000);
    chk("stall_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_cnt_total", cnt_total, 0);
    chk("midrst_cnt_shared", cnt_shared, 0);
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    chk("midrst_req_ready", req_ready, 1'b1);
    send(1'b0, 64'h8004_0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
